// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: one req/ack memory transaction per operation,
// with store lane steering, load extraction, alignment checks and an ack timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base_addr,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err_align,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR,
        S_TOUT
    } state_t;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ea_q, ea_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic [4:0]  rd_q, rd_d;
    logic        busy_q, busy_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        done_q, done_d;
    logic        err_align_q, err_align_d;
    logic        err_timeout_q, err_timeout_d;

    logic [31:0] ea_in;
    logic        bad_op;
    logic [3:0]  strb_in;
    logic [31:0] wdata_in;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [7:0]  cnt_inc;

    assign ea_in   = base_addr + offset;
    assign cnt_inc = cnt_q + 8'd1;

    // Classify and steer the incoming operation straight from the input operands.
    always_comb begin
        bad_op   = 1'b0;
        strb_in  = 4'b0000;
        wdata_in = store_data;
        unique case (funct3)
            F_B: begin
                strb_in  = 4'b0001 << ea_in[1:0];
                wdata_in = {4{store_data[7:0]}};
            end
            F_H: begin
                bad_op   = ea_in[0];
                strb_in  = ea_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{store_data[15:0]}};
            end
            F_W: begin
                bad_op  = (ea_in[1:0] != 2'b00);
                strb_in = 4'b1111;
            end
            F_BU:    bad_op = is_store;
            F_HU:    bad_op = is_store | ea_in[0];
            default: bad_op = 1'b1;
        endcase
    end

    assign ld_byte = mem_rdata[8*ea_q[1:0] +: 8];
    assign ld_half = mem_rdata[16*ea_q[1] +: 16];

    always_comb begin
        unique case (funct3_q)
            F_B:     ld_data = {{24{ld_byte[7]}}, ld_byte};
            F_BU:    ld_data = {24'd0, ld_byte};
            F_H:     ld_data = {{16{ld_half[15]}}, ld_half};
            F_HU:    ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // NOTE: every _d starts from its hold value or a pulse default, so no path
    // through this block can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ea_d          = ea_q;
        funct3_d      = funct3_q;
        is_store_d    = is_store_q;
        rd_d          = rd_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wstrb_d   = mem_wstrb_q;
        mem_wdata_d   = mem_wdata_q;
        wb_addr_d     = wb_addr_q;
        wb_data_d     = wb_data_q;
        wb_valid_d    = 1'b0;
        done_d        = 1'b0;
        err_align_d   = 1'b0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ea_d       = ea_in;
                    funct3_d   = funct3;
                    is_store_d = is_store;
                    rd_d       = rd_in;
                    cnt_d      = 8'd0;
                    if (bad_op) begin
                        state_d     = S_ERR;
                        err_align_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {ea_in[31:2], 2'b00};
                        mem_wstrb_d = is_store ? strb_in : 4'b0000;
                        mem_wdata_d = wdata_in;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                // Ack in the limit cycle still completes the transaction.
                if (mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!is_store_q && rd_q != 5'd0) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = rd_q;
                        wb_data_d  = ld_data;
                    end
                end else if (cnt_inc == TIMEOUT_LIM) begin
                    state_d       = S_TOUT;
                    mem_req_d     = 1'b0;
                    err_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            ea_q          <= 32'd0;
            funct3_q      <= 3'd0;
            is_store_q    <= 1'b0;
            rd_q          <= 5'd0;
            busy_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wstrb_q   <= 4'd0;
            mem_wdata_q   <= 32'd0;
            wb_valid_q    <= 1'b0;
            wb_addr_q     <= 5'd0;
            wb_data_q     <= 32'd0;
            done_q        <= 1'b0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ea_q          <= ea_d;
            funct3_q      <= funct3_d;
            is_store_q    <= is_store_d;
            rd_q          <= rd_d;
            busy_q        <= busy_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wstrb_q   <= mem_wstrb_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
            done_q        <= done_d;
            err_align_q   <= err_align_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign busy        = busy_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign done        = done_q;
    assign err_align   = err_align_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base_addr;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done;
    logic        err_align;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .base_addr(base_addr), .offset(offset), .store_data(store_data), .rd_in(rd_in),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .done(done), .err_align(err_align), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: rules written as plain arithmetic on the effective address.
    function automatic bit ref_legal(input bit st, input logic [2:0] f3, input logic [31:0] ea);
        int lo = int'(ea % 4);
        case (f3)
            3'd0:    return 1'b1;
            3'd4:    return !st;
            3'd1:    return (lo % 2) == 0;
            3'd5:    return !st && (lo % 2) == 0;
            3'd2:    return lo == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input bit st, input logic [2:0] f3, input logic [31:0] ea);
        int lo = int'(ea % 4);
        if (!st) return 4'd0;
        case (f3)
            3'd0:    return 4'(2 ** lo);
            3'd1:    return (lo >= 2) ? 4'd12 : 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'd0:    return (sd % 256) * 32'h0101_0101;
            3'd1:    return (sd % 65536) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] ea,
                                             input logic [31:0] rdata);
        logic [31:0] bv = (rdata / (32'd1 << (8 * (ea % 4)))) % 256;
        logic [31:0] hv = (rdata / (32'd1 << (16 * ((ea / 2) % 2)))) % 65536;
        case (f3)
            3'd0:    return (bv >= 128) ? bv - 32'd256 : bv;
            3'd4:    return bv;
            3'd1:    return (hv >= 32768) ? hv - 32'd65536 : hv;
            3'd5:    return hv;
            default: return rdata;
        endcase
    endfunction

    // Issue one operation at a negedge; ack arrives in REQ cycle dly+1.
    // Returns at the negedge where the DUT is back in IDLE.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd,
                         input int dly, input logic [31:0] rdata, input bit inject);
        logic [31:0] ea = base + off;
        bit ok = ref_legal(st, f3, ea);
        int exp_cycles = (dly + 1 <= int'(TO)) ? dly + 1 : int'(TO);
        int cycles = 0;
        is_store = st; funct3 = f3; base_addr = base; offset = off;
        store_data = sd; rd_in = rd; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        if (!ok) begin
            check("err_align", 32'(err_align), 32'd1);
            check("err_busy", 32'(busy), 32'd1);
            check("err_req", 32'(mem_req), 32'd0);
            check("err_done", 32'(done), 32'd0);
            @(negedge CLK);
            check("err_idle", {30'd0, busy, mem_req}, 32'd0);
            check("err_pulse", 32'(err_align), 32'd0);
            return;
        end
        while (mem_req && cycles < 20) begin
            cycles++;
            if (cycles == 1) begin
                check("addr", mem_addr, {ea[31:2], 2'b00});
                check("we", 32'(mem_we), 32'(st));
                check("strb", 32'(mem_wstrb), 32'(ref_strb(st, f3, ea)));
                if (st) check("wdata", mem_wdata, ref_wdata(f3, sd));
            end
            check("req_busy", 32'(busy), 32'd1);
            mem_ack   = (cycles == dly + 1);
            mem_rdata = mem_ack ? rdata : $urandom;
            if (inject) begin
                start = 1'b1; is_store = ~st; funct3 = 3'd2; base_addr = $urandom; rd_in = 5'd7;
            end
            @(negedge CLK);
            mem_ack = 1'b0;
            start   = 1'b0;
        end
        check("req_cycles", cycles, exp_cycles);
        check("busy_end", 32'(busy), 32'd1);
        if (dly + 1 <= int'(TO)) begin
            check("done", 32'(done), 32'd1);
            check("tout_lo", 32'(err_timeout), 32'd0);
            check("wb_valid", 32'(wb_valid), 32'(!st && rd != 5'd0));
            if (!st && rd != 5'd0) begin
                check("wb_addr", 32'(wb_addr), 32'(rd));
                check("wb_data", wb_data, ref_load(f3, ea, rdata));
            end
        end else begin
            check("tout", 32'(err_timeout), 32'd1);
            check("tout_done", 32'(done), 32'd0);
            check("tout_wb", 32'(wb_valid), 32'd0);
        end
        @(negedge CLK);
        check("idle", {29'd0, busy, done, wb_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; base_addr = '0;
        offset = '0; store_data = '0; rd_in = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ctl", {24'd0, busy, mem_req, mem_we, wb_valid, done, err_align, err_timeout, 1'b0}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wb", wb_data, 32'd0);
        rst = 1'b0;
        @(negedge CLK);

        do_op(0, 3'd0, 32'h1000, 32'd3, 32'd0, 5'd5, 0, 32'h80FF_FF00, 0);
        do_op(0, 3'd4, 32'h1000, 32'd3, 32'd0, 5'd5, 0, 32'h80FF_FF00, 0);
        do_op(0, 3'd5, 32'h1000, 32'd2, 32'd0, 5'd9, 1, 32'hBEEF_1234, 0);
        do_op(1, 3'd1, 32'h2000, 32'd2, 32'h1234_ABCD, 5'd3, 0, 32'd0, 0);
        do_op(0, 3'd2, 32'h1000, 32'd2, 32'd0, 5'd4, 0, 32'd0, 0);
        do_op(0, 3'd2, 32'h1000, 32'd0, 32'd0, 5'd0, 0, 32'hDEAD_BEEF, 0);
        do_op(0, 3'd2, 32'h1000, 32'd0, 32'd0, 5'd6, 3, 32'hCAFE_F00D, 1);
        do_op(1, 3'd2, 32'h3000, 32'd4, 32'h5555_AAAA, 5'd1, 9, 32'd0, 0);
        do_op(1, 3'd4, 32'h3000, 32'd0, 32'd0, 5'd1, 0, 32'd0, 0);
        do_op(0, 3'd3, 32'h3000, 32'd0, 32'd0, 5'd1, 0, 32'd0, 0);
        do_op(0, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd8, 0, 32'h0000_7F00, 0);

        // Reset while a request is outstanding.
        is_store = 1'b0; funct3 = 3'd2; base_addr = 32'h4000; offset = 32'd0; rd_in = 5'd2;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("pre_rst_req", 32'(mem_req), 32'd1);
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        @(negedge CLK);
        check("post_rst_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic [31:0] base = $urandom;
            logic [31:0] off = 32'($signed($urandom_range(0, 64)) - 32);
            do_op(1'($urandom_range(0, 1)), f3, base, off, $urandom,
                  5'($urandom_range(0, 31)), int'($urandom_range(0, 5)), $urandom,
                  1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
